// File: rtl/axi_lite_ram_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to single-cycle RAM bridge.
package axi_lite_ram_bridge_pkg;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespDecerr = 2'b11;

  localparam logic [31:0] RamBaseDefault = 32'h8000_0000;
  localparam logic [31:0] RamSizeDefault = 32'h0000_8000;

  typedef enum logic {
    RIdle,
    RResp
  } r_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WExec,
    WResp
  } w_state_e;

  // Map a window hit to the AXI response code.
  function automatic logic [1:0] resp_for(input logic hit);
    return hit ? AxiRespOkay : AxiRespDecerr;
  endfunction

endpackage

// File: rtl/axi_lite_ram_bridge_strb2mask.sv
// Expands an AXI byte-strobe vector into a per-bit write mask.
module axi_lite_ram_bridge_strb2mask #(
  parameter int unsigned STRB_W = 8
) (
  input  logic [STRB_W-1:0]   strb_i,
  output logic [STRB_W*8-1:0] mask_o
);

  // Replicate each strobe bit across its byte lane.
  always_comb begin
    mask_o = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      mask_o[i*8 +: 8] = {8{strb_i[i]}};
    end
  end

endmodule

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave bridging LSU loads/stores onto a single-cycle data RAM port.
// Read and write paths are independent FSMs; accesses outside the window get DECERR.
module axi_lite_ram_bridge
  import axi_lite_ram_bridge_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 64,
  parameter logic [ADDR_W-1:0]  RAM_BASE = ADDR_W'(RamBaseDefault),
  parameter logic [ADDR_W-1:0]  RAM_SIZE = ADDR_W'(RamSizeDefault),
  localparam int unsigned       STRB_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // read address / data
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  // write address / data / response
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  // ram port
  output logic              ram_ren_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [DATA_W-1:0] ram_wmask_o
);

  // Start-byte window test; the offset compare avoids overflow at the top of the space.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    return (addr >= RAM_BASE) && ((addr - RAM_BASE) < RAM_SIZE);
  endfunction

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e          r_state_q, r_state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ar_hs;
  logic              ar_hit;

  // Ready is forced low while reset is held so the bus sees a quiet slave.
  assign s_arready   = (r_state_q == RIdle) && !rst;
  assign ar_hs       = s_arvalid && s_arready;
  assign ar_hit      = in_window(s_araddr);
  assign ram_ren_o   = ar_hs && ar_hit;
  assign ram_raddr_o = s_araddr;
  assign s_rvalid    = (r_state_q == RResp);
  assign s_rdata     = rdata_q;
  assign s_rresp     = rresp_q;

  // Read next-state: capture RAM data on the AR handshake, hold until R handshake.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          rdata_d   = ar_hit ? ram_rdata_i : '0;
          rresp_d   = resp_for(ar_hit);
          r_state_d = RResp;
        end
      end
      RResp: begin
        if (s_rready) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Read state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      rdata_q   <= '0;
      rresp_q   <= AxiRespOkay;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e          w_state_q, w_state_d;
  logic              aw_cap_q, aw_cap_d;
  logic              w_cap_q, w_cap_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_hs;
  logic              w_hs;
  logic              aw_hit;
  logic [DATA_W-1:0] wmask;

  assign s_awready = (w_state_q == WIdle) && !aw_cap_q && !rst;
  assign s_wready  = (w_state_q == WIdle) && !w_cap_q && !rst;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign aw_hit    = in_window(awaddr_q);

  axi_lite_ram_bridge_strb2mask #(
    .STRB_W (STRB_W)
  ) u_strb2mask (
    .strb_i (wstrb_q),
    .mask_o (wmask)
  );

  assign ram_wen_o   = (w_state_q == WExec) && aw_hit;
  assign ram_waddr_o = awaddr_q;
  assign ram_wmask_o = wmask;
  assign ram_wdata_o = wdata_q & wmask;
  assign s_bvalid    = (w_state_q == WResp);
  assign s_bresp     = bresp_q;

  // Write next-state: collect AW and W in any order, issue one RAM write, then respond.
  always_comb begin
    w_state_d = w_state_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          awaddr_d = s_awaddr;
        end
        if (w_hs) begin
          w_cap_d = 1'b1;
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
        end
        if (aw_cap_d && w_cap_d) begin
          w_state_d = WExec;
        end
      end
      WExec: begin
        bresp_d   = resp_for(aw_hit);
        w_state_d = WResp;
      end
      WResp: begin
        if (s_bready) begin
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Write state and holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= AxiRespOkay;
    end else begin
      w_state_q <= w_state_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Directed bench for axi_lite_ram_bridge with a behavioural 4096 x 64b RAM.
module tb_axi_lite_ram_bridge;

  logic        clk;
  logic        rst;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_bresp;
  logic        ram_ren_o, ram_wen_o;
  logic [31:0] ram_raddr_o, ram_waddr_o;
  logic [63:0] ram_rdata_i, ram_wdata_o, ram_wmask_o;

  logic [63:0] mem [4096];
  logic        seed;
  int          ren_cnt;
  int          wen_cnt;
  int          wen_base;
  int          nvec;
  int          nerr;

  axi_lite_ram_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_araddr    (s_araddr),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_awaddr    (s_awaddr),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_bresp     (s_bresp),
    .ram_ren_o   (ram_ren_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_wen_o   (ram_wen_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wmask_o (ram_wmask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, masked posedge write; window base is 32 KiB aligned.
  assign ram_rdata_i = mem[ram_raddr_o[14:3]];

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 64'h0;
      mem[2] <= 64'h1122_3344_5566_7788;
    end else if (ram_wen_o) begin
      mem[ram_waddr_o[14:3]] <= (mem[ram_waddr_o[14:3]] & ~ram_wmask_o) | ram_wdata_o;
    end
  end

  // Strobe counters sampled on the active edge.
  always @(posedge clk) begin
    if (ram_ren_o) ren_cnt <= ren_cnt + 1;
    if (ram_wen_o) wen_cnt <= wen_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0; nerr = 0; ren_cnt = 0; wen_cnt = 0; wen_base = 0;
    rst = 1'b1; seed = 1'b1;
    s_arvalid = 0; s_araddr = '0; s_rready = 0;
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_bready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_ren", 64'(ram_ren_o), 64'd0);
    chk("rst_wen", 64'(ram_wen_o), 64'd0);
    chk("rst_rdata", s_rdata, 64'd0);
    chk("rst_wmask", ram_wmask_o, 64'd0);
    seed = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_arready", 64'(s_arready), 64'd1);
    chk("post_rst_awready", 64'(s_awready), 64'd1);

    // 1: in-window read of word 2
    @(negedge clk); s_arvalid = 1; s_araddr = 32'h8000_0010; s_rready = 1; #1;
    chk("t1_ren", 64'(ram_ren_o), 64'd1);
    chk("t1_raddr", 64'(ram_raddr_o), 64'h8000_0010);
    @(negedge clk); s_arvalid = 0; #1;
    chk("t1_rvalid", 64'(s_rvalid), 64'd1);
    chk("t1_rdata", s_rdata, 64'h1122_3344_5566_7788);
    chk("t1_rresp", 64'(s_rresp), 64'd0);
    chk("t1_arready_busy", 64'(s_arready), 64'd0);
    @(negedge clk); #1;
    chk("t1_rvalid_done", 64'(s_rvalid), 64'd0);
    chk("t1_ren_count", 64'(ren_cnt), 64'd1);

    // 2: W two cycles ahead of AW, partial strobe
    s_bready = 1;
    @(negedge clk); s_wvalid = 1; s_wdata = 64'hFFFF_FFFF_FFFF_FFFF; s_wstrb = 8'h0F; #1;
    chk("t2_wready", 64'(s_wready), 64'd1);
    @(negedge clk); s_wvalid = 0; #1;
    chk("t2_wready_captured", 64'(s_wready), 64'd0);
    chk("t2_awready_open", 64'(s_awready), 64'd1);
    chk("t2_no_early_wen", 64'(ram_wen_o), 64'd0);
    @(negedge clk); s_awvalid = 1; s_awaddr = 32'h8000_0020; #1;
    @(negedge clk); s_awvalid = 0; #1;
    chk("t2_wen", 64'(ram_wen_o), 64'd1);
    chk("t2_wmask", ram_wmask_o, 64'h0000_0000_FFFF_FFFF);
    chk("t2_wdata", ram_wdata_o, 64'h0000_0000_FFFF_FFFF);
    chk("t2_waddr", 64'(ram_waddr_o), 64'h8000_0020);
    @(negedge clk); #1;
    chk("t2_bvalid", 64'(s_bvalid), 64'd1);
    chk("t2_bresp", 64'(s_bresp), 64'd0);
    chk("t2_wen_single", 64'(ram_wen_o), 64'd0);
    @(negedge clk); #1;
    chk("t2_bvalid_done", 64'(s_bvalid), 64'd0);
    chk("t2_wen_count", 64'(wen_cnt), 64'd1);
    chk("t2_mem4", mem[4], 64'h0000_0000_FFFF_FFFF);

    // 3: AW+W same cycle, B back-pressured for 5 cycles
    s_bready = 0; wen_base = wen_cnt;
    @(negedge clk);
    s_awvalid = 1; s_awaddr = 32'h8000_0028;
    s_wvalid = 1; s_wdata = 64'hA5A5_A5A5_A5A5_A5A5; s_wstrb = 8'hFF; #1;
    @(negedge clk); s_awvalid = 0; s_wvalid = 0; #1;
    chk("t3_wen", 64'(ram_wen_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t3_bvalid_hold", 64'(s_bvalid), 64'd1);
      chk("t3_bresp_hold", 64'(s_bresp), 64'd0);
      chk("t3_awready_low", 64'(s_awready), 64'd0);
      chk("t3_wready_low", 64'(s_wready), 64'd0);
    end
    s_bready = 1;
    @(negedge clk); #1;
    chk("t3_bvalid_done", 64'(s_bvalid), 64'd0);
    chk("t3_wen_count", 64'(wen_cnt), 64'(wen_base + 1));
    chk("t3_mem5", mem[5], 64'hA5A5_A5A5_A5A5_A5A5);

    // 4: out-of-window read and write
    @(negedge clk); s_arvalid = 1; s_araddr = 32'h1000_0000; s_rready = 1; #1;
    chk("t4_no_ren", 64'(ram_ren_o), 64'd0);
    @(negedge clk); s_arvalid = 0; #1;
    chk("t4_rvalid", 64'(s_rvalid), 64'd1);
    chk("t4_rdata", s_rdata, 64'd0);
    chk("t4_rresp", 64'(s_rresp), 64'd3);
    @(negedge clk); #1;
    chk("t4_ren_count", 64'(ren_cnt), 64'd1);
    wen_base = wen_cnt;
    @(negedge clk);
    s_awvalid = 1; s_awaddr = 32'h9000_0000;
    s_wvalid = 1; s_wdata = 64'h1234; s_wstrb = 8'hFF; #1;
    @(negedge clk); s_awvalid = 0; s_wvalid = 0; #1;
    chk("t4_no_wen", 64'(ram_wen_o), 64'd0);
    @(negedge clk); #1;
    chk("t4_bvalid", 64'(s_bvalid), 64'd1);
    chk("t4_bresp", 64'(s_bresp), 64'd3);
    @(negedge clk); #1;
    chk("t4_wen_count", 64'(wen_cnt), 64'(wen_base));

    // 5: read and write to the same word on the same edge
    @(negedge clk);
    s_awvalid = 1; s_awaddr = 32'h8000_0010;
    s_wvalid = 1; s_wdata = 64'hDEAD_BEEF_CAFE_F00D; s_wstrb = 8'hFF; #1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    s_arvalid = 1; s_araddr = 32'h8000_0010; #1;
    chk("t5_wen", 64'(ram_wen_o), 64'd1);
    chk("t5_ren", 64'(ram_ren_o), 64'd1);
    @(negedge clk); s_arvalid = 0; #1;
    chk("t5_rdata_old", s_rdata, 64'h1122_3344_5566_7788);
    chk("t5_bvalid", 64'(s_bvalid), 64'd1);
    @(negedge clk); s_arvalid = 1; #1;
    @(negedge clk); s_arvalid = 0; #1;
    chk("t5_rdata_new", s_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk); #1;
    chk("t5_ren_count", 64'(ren_cnt), 64'd3);

    // 6a: reset while in R_RESP
    s_rready = 0;
    @(negedge clk); s_arvalid = 1; s_araddr = 32'h8000_0018; #1;
    @(negedge clk); s_arvalid = 0; #1;
    chk("t6_rvalid_pre", 64'(s_rvalid), 64'd1);
    rst = 1; #1;
    chk("t6_rvalid_rst", 64'(s_rvalid), 64'd0);
    chk("t6_arready_rst", 64'(s_arready), 64'd0);
    chk("t6_rdata_rst", s_rdata, 64'd0);
    @(negedge clk);
    rst = 0; s_arvalid = 1; s_araddr = 32'h8000_0010; s_rready = 1; #1;
    chk("t6_arready_after", 64'(s_arready), 64'd1);
    chk("t6_ren_after", 64'(ram_ren_o), 64'd1);
    @(negedge clk); s_arvalid = 0; #1;
    chk("t6_rdata_after", s_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk); #1;

    // 6b: reset while in W_EXEC
    wen_base = wen_cnt;
    @(negedge clk);
    s_awvalid = 1; s_awaddr = 32'h8000_0030;
    s_wvalid = 1; s_wdata = 64'h5555_5555_5555_5555; s_wstrb = 8'hFF; s_bready = 1; #1;
    @(negedge clk); s_awvalid = 0; s_wvalid = 0; #1;
    chk("t6_wen_pre", 64'(ram_wen_o), 64'd1);
    rst = 1; #1;
    chk("t6_wen_rst", 64'(ram_wen_o), 64'd0);
    chk("t6_bvalid_rst", 64'(s_bvalid), 64'd0);
    chk("t6_awready_rst", 64'(s_awready), 64'd0);
    @(negedge clk);
    rst = 0;
    s_awvalid = 1; s_awaddr = 32'h8000_0038;
    s_wvalid = 1; s_wdata = 64'h7777_7777_7777_7777; s_wstrb = 8'hFF; #1;
    chk("t6_awready_after", 64'(s_awready), 64'd1);
    chk("t6_wready_after", 64'(s_wready), 64'd1);
    @(negedge clk); s_awvalid = 0; s_wvalid = 0; #1;
    chk("t6_wen_after", 64'(ram_wen_o), 64'd1);
    chk("t6_waddr_after", 64'(ram_waddr_o), 64'h8000_0038);
    @(negedge clk); #1;
    chk("t6_bvalid_after", 64'(s_bvalid), 64'd1);
    chk("t6_bresp_after", 64'(s_bresp), 64'd0);
    @(negedge clk); #1;
    chk("t6_wen_count", 64'(wen_cnt), 64'(wen_base + 1));
    chk("t6_mem6_untouched", mem[6], 64'd0);
    chk("t6_mem7", mem[7], 64'h7777_7777_7777_7777);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
